temp_entry_ctrl: RTL and testbench

//   Clocked sequencer for keypad entry of a 3-digit BCD temperature. Takes

---
 rtl/temp_entry_if.sv | 32 +++
 rtl/temp_entry_ctrl.sv | 141 ++++++++++++++
 tb/tb_temp_entry_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/temp_entry_if.sv
// Keypad-side bus of the temperature entry sequencer: digit/enter inputs,
// progress state, committed and previous BCD values, and result pulses.
interface temp_entry_if;
  logic       enter;
  logic [3:0] value;
  logic [1:0] input_state;
  logic [3:0] temp_value_ones;
  logic [3:0] temp_value_tens;
  logic [3:0] temp_value_huns;
  logic [3:0] temp_value_ones_old;
  logic [3:0] temp_value_tens_old;
  logic [3:0] temp_value_huns_old;
  logic       commit;
  logic       err;
  logic       timeout;

  modport master (
    output enter, value,
    input  input_state,
    input  temp_value_ones, temp_value_tens, temp_value_huns,
    input  temp_value_ones_old, temp_value_tens_old, temp_value_huns_old,
    input  commit, err, timeout
  );

  modport slave (
    input  enter, value,
    output input_state,
    output temp_value_ones, temp_value_tens, temp_value_huns,
    output temp_value_ones_old, temp_value_tens_old, temp_value_huns_old,
    output commit, err, timeout
  );
endinterface

// File: rtl/temp_entry_ctrl.sv
// Keypad entry sequencer for a 3-digit BCD temperature (ones, tens, hundreds).
// Optional feature: define TEMP_ENTRY_ESC_EN to make digit 4'hB an escape key.
module temp_entry_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [11:0] MAX_BCD        = 12'h999
) (
  input logic         clk,
  input logic         rst,
  temp_entry_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_ONES = 2'd0;
  localparam logic [1:0] ST_TENS = 2'd1;
  localparam logic [1:0] ST_HUNS = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          enter_q;
  logic [3:0]    pend_ones_q, pend_ones_d;
  logic [3:0]    pend_tens_q, pend_tens_d;
  logic [11:0]   cur_q, cur_d;
  logic [11:0]   old_q, old_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          commit_q, commit_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  logic        press;
  logic        digit_ok;
  logic [11:0] cand;

  assign press    = bus.enter & ~enter_q;
  assign digit_ok = (bus.value <= 4'd9);
  assign cand     = {bus.value, pend_tens_q, pend_ones_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    pend_ones_d = pend_ones_q;
    pend_tens_d = pend_tens_q;
    cur_d       = cur_q;
    old_d       = old_q;
    commit_d    = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;

    // Idle timer only runs while a partial entry is pending; it saturates.
    if (state_q == ST_ONES || press) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end

    if (press) begin
`ifdef TEMP_ENTRY_ESC_EN
      if (bus.value == 4'hB) begin
        pend_ones_d = '0;
        pend_tens_d = '0;
        state_d     = ST_ONES;
      end else
`endif
      if (!digit_ok) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          ST_ONES: begin
            pend_ones_d = bus.value;
            state_d     = ST_TENS;
          end
          ST_TENS: begin
            pend_tens_d = bus.value;
            state_d     = ST_HUNS;
          end
          ST_HUNS: begin
            // Packed BCD orders the same as its decimal value, so a plain compare works.
            if (cand <= MAX_BCD) begin
              old_d    = cur_q;
              cur_d    = cand;
              commit_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            pend_ones_d = '0;
            pend_tens_d = '0;
            state_d     = ST_ONES;
          end
          default: state_d = ST_ONES;
        endcase
      end
    end else if (state_q != ST_ONES && timer_q == TIMER_LAST) begin
      timeout_d   = 1'b1;
      pend_ones_d = '0;
      pend_tens_d = '0;
      state_d     = ST_ONES;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ONES;
      enter_q     <= 1'b0;
      pend_ones_q <= '0;
      pend_tens_q <= '0;
      cur_q       <= '0;
      old_q       <= '0;
      timer_q     <= '0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enter_q     <= bus.enter;
      pend_ones_q <= pend_ones_d;
      pend_tens_q <= pend_tens_d;
      cur_q       <= cur_d;
      old_q       <= old_d;
      timer_q     <= timer_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.input_state         = state_q;
  assign bus.temp_value_ones     = cur_q[3:0];
  assign bus.temp_value_tens     = cur_q[7:4];
  assign bus.temp_value_huns     = cur_q[11:8];
  assign bus.temp_value_ones_old = old_q[3:0];
  assign bus.temp_value_tens_old = old_q[7:4];
  assign bus.temp_value_huns_old = old_q[11:8];
  assign bus.commit              = commit_q;
  assign bus.err                 = err_q;
  assign bus.timeout             = timeout_q;

endmodule

// File: tb/tb_temp_entry_ctrl.sv
// Scoreboard bench for temp_entry_ctrl: directed key sequences push expected
// result pulses; a monitor pops and compares whenever a pulse appears.
module tb_temp_entry_ctrl;

  localparam int unsigned TO      = 16;
  localparam logic [11:0] MAX_VAL = 12'h150;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  temp_entry_if bus();

  temp_entry_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_BCD       (MAX_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef enum logic [1:0] {EV_COMMIT = 2'd0, EV_ERR = 2'd1, EV_TIMEOUT = 2'd2} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [11:0] cur;
    logic [11:0] old;
    logic [1:0]  state;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] cur_out();
    return {bus.temp_value_huns, bus.temp_value_tens, bus.temp_value_ones};
  endfunction

  function automatic logic [11:0] old_out();
    return {bus.temp_value_huns_old, bus.temp_value_tens_old, bus.temp_value_ones_old};
  endfunction

  task automatic expect_ev(input ev_e k, input logic [11:0] c, input logic [11:0] o,
                           input logic [1:0] s);
    exp_t e;
    e.kind  = k;
    e.cur   = c;
    e.old   = o;
    e.state = s;
    sb.push_back(e);
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    bus.value = v;
    bus.enter = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.enter = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: one expected entry per observed result pulse.
  exp_t mon_e;
  ev_e  mon_kind;
  always @(negedge clk) begin
    if (!rst && (bus.commit || bus.err || bus.timeout)) begin
      check("pulse_onehot", 32'(int'(bus.commit) + int'(bus.err) + int'(bus.timeout)), 32'd1);
      mon_kind = bus.commit ? EV_COMMIT : (bus.err ? EV_ERR : EV_TIMEOUT);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.commit, bus.err, bus.timeout}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind",  32'(mon_kind),        32'(mon_e.kind));
        check("current",     32'(cur_out()),       32'(mon_e.cur));
        check("old",         32'(old_out()),       32'(mon_e.old));
        check("input_state", 32'(bus.input_state), 32'(mon_e.state));
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_state"},  32'(bus.input_state), 32'd0);
    check({tag, "_cur"},    32'(cur_out()),       32'd0);
    check({tag, "_old"},    32'(old_out()),       32'd0);
    check({tag, "_pulses"}, {29'd0, bus.commit, bus.err, bus.timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.enter = 1'b0;
    bus.value = 4'd0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Basic commit, ones digit first.
    expect_ev(EV_COMMIT, 12'h123, 12'h000, 2'd0);
    press(4'd3);
    @(negedge clk);
    check("state_after_ones", 32'(bus.input_state), 32'd1);
    press(4'd2);
    @(negedge clk);
    check("state_after_tens", 32'(bus.input_state), 32'd2);
    press(4'd1);
    drain(4);

    // Second commit shifts the first value into old.
    expect_ev(EV_COMMIT, 12'h145, 12'h123, 2'd0);
    press(4'd5); press(4'd4); press(4'd1);
    drain(4);

    // 555 exceeds 150: range error, nothing committed.
    expect_ev(EV_ERR, 12'h145, 12'h123, 2'd0);
    press(4'd5); press(4'd5); press(4'd5);
    drain(4);

    // Invalid digit in ONES.
    expect_ev(EV_ERR, 12'h145, 12'h123, 2'd0);
    press(4'hA);
    drain(4);

    // Held enter is taken once.
    @(negedge clk);
    bus.value = 4'd7;
    bus.enter = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("held_enter_state", 32'(bus.input_state), 32'd1);
    bus.enter = 1'b0;
    expect_ev(EV_TIMEOUT, 12'h145, 12'h123, 2'd0);
    drain(40);

    // Idle timeout after a single digit.
    expect_ev(EV_TIMEOUT, 12'h145, 12'h123, 2'd0);
    press(4'd1);
    drain(40);

    // Press lands on the expiry cycle: press wins, no timeout.
    press(4'd1);
    repeat (14) @(posedge clk);
    press(4'd2);
    @(negedge clk);
    check("expiry_press_state", 32'(bus.input_state), 32'd2);
    expect_ev(EV_COMMIT, 12'h121, 12'h145, 2'd0);
    press(4'd1);
    drain(4);

    // Range boundary: 150 commits, 151 is rejected.
    expect_ev(EV_COMMIT, 12'h150, 12'h121, 2'd0);
    press(4'd0); press(4'd5); press(4'd1);
    drain(4);
    expect_ev(EV_ERR, 12'h150, 12'h121, 2'd0);
    press(4'd1); press(4'd5); press(4'd1);
    drain(4);

    // Reset in the middle of an entry.
    press(4'd4); press(4'd4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_cleared("midreset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("after_reset");

    // Digit B: escape when enabled, invalid digit otherwise.
`ifdef TEMP_ENTRY_ESC_EN
    press(4'd1);
    press(4'hB);
    @(negedge clk);
    check("escape_state", 32'(bus.input_state), 32'd0);
    drain(4);
`else
    expect_ev(EV_ERR, 12'h000, 12'h000, 2'd1);
    press(4'd1);
    press(4'hB);
    drain(4);
    @(negedge clk);
    check("digit_b_state", 32'(bus.input_state), 32'd1);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
